alu_divider: RTL and testbench
==============================

Name: alu_divider

Overview:
- Iterative radix-2 restoring divider producing a 32-bit quotient and a 32-bit remainder.
- Supplies the DIV operation that the single-cycle ALU cannot provide; sits beside the ALU in the execute stage.
- The CPU core drives a start/busy/valid handshake and stalls while the divider is busy.
- Supports unsigned and signed (truncating) division, and flags divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- DBZ_QUOT, all-ones, quotient value returned on divide-by-zero.

Ports:
- clk  input  1  rising-edge clock.
- reset_b  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- signed_op  input  1  1 = signed two's-complement division, 0 = unsigned; captured with start.
- din_a  input  WIDTH  dividend; captured with start.
- din_b  input  WIDTH  divisor; captured with start.
- busy  output  1  operation in progress; new start ignored while high.
- valid  output  1  one-cycle pulse: quotient/remainder/flags are new.
- quotient  output  WIDTH  result quotient; holds until the next valid.
- remainder  output  WIDTH  result remainder; holds until the next valid.
- dbz  output  1  divide-by-zero flag for the last result.
- vout  output  1  signed overflow flag (most-negative / -1) for the last result.

Behaviour:
- Reset (reset_b low, asynchronous): state=IDLE; busy, valid, dbz, vout = 0; quotient, remainder = 0; iteration counter = 0.
- States: IDLE, RUN, FIX.
- Cycle numbering: start is high in cycle 0 and is sampled on the edge ending cycle 0.

- IDLE
  - start=1 and din_b≠0: latch the operand magnitudes (absolute value when signed_op=1 and the sign bit is set), the quotient sign (a[31]^b[31]), the remainder sign (a[31]) and signed_op; clear the partial remainder; counter=0; go to RUN.
  - start=1 and din_b=0: go to FIX with the dbz path selected.
  - start=0: stay in IDLE.

- RUN
  - Each cycle: shift {partial remainder, dividend} left by 1, then trial subtract the divisor magnitude.
  - Non-negative trial result: keep the difference and set quotient bit 1. Otherwise restore and set quotient bit 0.
  - Counter increments each cycle; after WIDTH iterations (cycles 1..32), go to FIX.

- FIX (cycle 33)
  - Negate the quotient if the quotient sign is set and signed_op=1.
  - Negate the remainder if the remainder sign is set and signed_op=1.
  - Register quotient, remainder, dbz, vout; assert valid for the next cycle; go to IDLE.

- Timing
  - Normal operation: busy high in cycles 1..33; valid high in cycle 34 only; latency 34 cycles start-to-valid.
  - Divide-by-zero: busy high in cycle 1 only; valid high in cycle 2.
  - Outputs: quotient=DBZ_QUOT, remainder=din_a (unmodified), dbz=1, vout=0.

- Signed overflow
  - 0x80000000 / 0xFFFFFFFF with signed_op=1 gives quotient=0x80000000, remainder=0, vout=1. This falls out naturally from magnitude division plus negation wraparound; vout is detected explicitly from the latched operands.
  - vout=0 for all unsigned operations and all other signed cases.

- Handshake
  - busy is low in the valid cycle, so start may be asserted in the valid cycle and is accepted (back-to-back operation).
  - start while busy=1 is ignored; it causes no restart and no queueing.
  - Operand inputs need only be stable in the start cycle.

- Flags and results
  - dbz and vout update only with valid; otherwise they hold their last values.
  - Dividend 0 with a nonzero divisor gives quotient 0, remainder 0.
  - Divisor 1 gives quotient=dividend, remainder 0.
  - Unsigned dividend < divisor gives quotient 0, remainder=dividend.

- Reset mid-operation
  - Immediately aborts: IDLE, all outputs cleared, no valid pulse.
  - The first start after reset_b rises behaves normally.

Test Plan:
1. Unsigned 100 / 7, start in cycle 0 -> busy cycles 1..33, valid only in cycle 34, quotient=14, remainder=2, dbz=0, vout=0.
2. Signed -7 / 2 (0xFFFFFFF9, 0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1. Unsigned 0xFFFFFFF9 / 2 -> quotient=0x7FFFFFFC, remainder=1.
3. Divide-by-zero 0x1234 / 0 (signed and unsigned) -> valid in cycle 2, quotient=0xFFFFFFFF, remainder=0x1234, dbz=1. The following 10/3 returns dbz=0.
4. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, vout=1. Same operands unsigned -> quotient=0, remainder=0x80000000, vout=0.
5. Back-to-back: start 50/5 in cycle 0, second start 9/4 held in cycles 5..34 -> first valid in cycle 34 (10,0). The second start is accepted in cycle 34 and its valid arrives in cycle 68 (2,1). No restart occurs during cycles 5..33.
6. Reset mid-op: start 1000/3, drive reset_b low in cycle 10 -> busy, valid, quotient, remainder cleared asynchronously and no valid pulse follows. After release, 1000/3 -> quotient=333, remainder=1 after 34 cycles.

Source files
------------

// File: rtl/alu_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed operands
// handled as magnitudes with a sign fix-up cycle at the end.
module alu_divider #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] DBZ_QUOT = '1
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             vout
);
    localparam int               CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             sop_q, sop_d;
    logic             ovf_q, ovf_d;
    logic             dbzsel_q, dbzsel_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic             vout_q, vout_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    assign a_mag = (signed_op && din_a[WIDTH-1]) ? (~din_a + ONE) : din_a;
    assign b_mag = (signed_op && din_b[WIDTH-1]) ? (~din_b + ONE) : din_b;

    // Partial remainder is one bit wider before the subtract so large unsigned divisors fit.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        sop_d    = sop_q;
        ovf_d    = ovf_q;
        dbzsel_d = dbzsel_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        quot_d   = quot_q;
        rmd_d    = rmd_q;
        dbz_d    = dbz_q;
        vout_d   = vout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    rem_d  = '0;
                    sop_d  = signed_op;
                    if (din_b == '0) begin
                        dbzsel_d = 1'b1;
                        dvd_d    = din_a;
                        state_d  = FIX;
                    end else begin
                        dbzsel_d = 1'b0;
                        dvd_d    = a_mag;
                        dvs_d    = b_mag;
                        qsign_d  = din_a[WIDTH-1] ^ din_b[WIDTH-1];
                        rsign_d  = din_a[WIDTH-1];
                        ovf_d    = signed_op && (din_a == MOST_NEG) && (din_b == '1);
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (dbzsel_q) begin
                    quot_d = DBZ_QUOT;
                    rmd_d  = dvd_q;
                    dbz_d  = 1'b1;
                    vout_d = 1'b0;
                end else begin
                    quot_d = (sop_q && qsign_q) ? (~dvd_q + ONE) : dvd_q;
                    rmd_d  = (sop_q && rsign_q) ? (~rem_q + ONE) : rem_q;
                    dbz_d  = 1'b0;
                    vout_d = ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            sop_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dbzsel_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
            dbz_q    <= 1'b0;
            vout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            sop_q    <= sop_d;
            ovf_q    <= ovf_d;
            dbzsel_q <= dbzsel_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
            dbz_q    <= dbz_d;
            vout_q   <= vout_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign dbz       = dbz_q;
    assign vout      = vout_q;
endmodule

// File: tb/tb_alu_divider.sv
// Directed and randomized checks of alu_divider: timing of busy/valid, results, flags,
// back-to-back handshake and asynchronous reset abort.
module tb_alu_divider;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] din_a = '0;
    logic [31:0] din_b = '0;
    logic        busy, valid, dbz, vout;
    logic [31:0] quotient, remainder;

    alu_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .signed_op(signed_op),
        .din_a(din_a), .din_b(din_b), .busy(busy), .valid(valid),
        .quotient(quotient), .remainder(remainder), .dbz(dbz), .vout(vout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        d;
        logic        v;
    } res_t;

    res_t sb[$];
    res_t last;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] q, input logic [31:0] r, input logic d, input logic v);
        res_t e;
        e.q = q; e.r = r; e.d = d; e.v = v;
        sb.push_back(e);
    endtask

    // Reference built on the simulator's own 64-bit arithmetic.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t   e;
        longint sa, sb64, sq, sr;
        e.d = 1'b0;
        e.v = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'h0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.d = 1'b1; e.v = 1'b0;
        end else if (s) begin
            sa = longint'($signed(a)); sb64 = longint'($signed(b));
            sq = sa / sb64; sr = sa % sb64;
            e.q = sq[31:0]; e.r = sr[31:0];
        end else begin
            e.q = a / b; e.r = a % b;
        end
        return e;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        start = 1'b1; din_a = a; din_b = b; signed_op = s;
        @(posedge clk);
        #1;
        start = 1'b0; din_a = $urandom; din_b = $urandom; signed_op = 1'($urandom_range(0, 1));
    endtask

    // Walks cycles 1..lat of an accepted op; optionally raises a second start at cycle 5.
    task automatic await(input string tag, input int lat, input bit b2b);
        res_t e;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", tag, k), {31'b0, busy}, {31'b0, k < lat});
            chk($sformatf("%s valid c%0d", tag, k), {31'b0, valid}, {31'b0, k == lat});
            if (k == lat - 1) begin
                chk({tag, " hold q"}, quotient, last.q);
                chk({tag, " hold r"}, remainder, last.r);
                chk({tag, " hold flags"}, {30'b0, dbz, vout}, {30'b0, last.d, last.v});
            end
            if (b2b && k == 5) begin
                start = 1'b1; din_a = 32'd9; din_b = 32'd4; signed_op = 1'b0;
                push(32'd2, 32'd1, 1'b0, 1'b0);
            end
            if (k == lat) begin
                n_assert++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL %s scoreboard: observed empty expected entry", tag);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, " quotient"}, quotient, e.q);
                    chk({tag, " remainder"}, remainder, e.r);
                    chk({tag, " dbz"}, {31'b0, dbz}, {31'b0, e.d});
                    chk({tag, " vout"}, {31'b0, vout}, {31'b0, e.v});
                    last = e;
                end
                $display("txn %s: q=%08h r=%08h dbz=%0b vout=%0b", tag, quotient, remainder, dbz, vout);
            end
        end
        if (b2b) begin
            @(posedge clk);
            #1;
            start = 1'b0; din_a = $urandom; din_b = $urandom;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] q, input logic [31:0] r, input logic d, input logic v);
        push(q, r, d, v);
        launch(a, b, s);
        await(tag, (b == 32'h0) ? 2 : 34, 1'b0);
    endtask

    initial begin
        res_t e;
        logic [31:0] ra, rb;
        logic        rs;
        bit          seen_valid;
        last = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy/valid", {30'b0, busy, valid}, 32'h0);
        chk("reset quotient", quotient, 32'h0);
        chk("reset remainder", remainder, 32'h0);
        chk("reset flags", {30'b0, dbz, vout}, 32'h0);
        reset_b = 1'b1;

        op("u100/7",      32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 1'b0);
        op("s-7/2",       32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op("s7/-2",       32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
        op("uFFFFFFF9/2", 32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1,         1'b0, 1'b0);
        op("s1234/0",     32'h1234,      32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234,      1'b1, 1'b0);
        op("u1234/0",     32'h1234,      32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234,      1'b1, 1'b0);
        op("u10/3",       32'd10,        32'd3,         1'b0, 32'd3,         32'd1,         1'b0, 1'b0);
        op("s ovf",       32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0,         1'b0, 1'b1);
        op("u minneg",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h8000_0000, 1'b0, 1'b0);
        op("u0/5",        32'd0,         32'd5,         1'b0, 32'd0,         32'd0,         1'b0, 1'b0);
        op("u12345/1",    32'd12345,     32'd1,         1'b0, 32'd12345,     32'd0,         1'b0, 1'b0);
        op("u5/9",        32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         1'b0, 1'b0);
        op("uFFFFFFFF/FFFFFFFE", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1,  32'd1,         1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            rs = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs);
            op($sformatf("rand%0d", i), ra, rb, rs, e.q, e.r, e.d, e.v);
        end

        push(32'd10, 32'd0, 1'b0, 1'b0);
        launch(32'd50, 32'd5, 1'b0);
        await("b2b first", 34, 1'b1);
        await("b2b second", 34, 1'b0);

        launch(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset_b = 1'b0;
        #1;
        chk("abort busy/valid", {30'b0, busy, valid}, 32'h0);
        chk("abort quotient", quotient, 32'h0);
        chk("abort remainder", remainder, 32'h0);
        chk("abort flags", {30'b0, dbz, vout}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1;
        last = '0;
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) seen_valid = 1'b1;
        end
        chk("no valid after abort", {31'b0, seen_valid}, 32'h0);
        op("u1000/3 after reset", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 1'b0);

        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
